// File: rtl/sb_config_loader.sv
// Serial configuration loader for a decoder-addressed switch block.
// Accepts one configuration bit per valid/ready handshake and turns each
// bit into a single-cycle write (enable/address/data_in) to the switch block.
module sb_config_loader #(
  parameter int NUM_MEM      = 18,
  parameter int BITS_PER_MEM = 2,
  parameter int ADDR_W       = 6
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  input  logic              cfg_data,
  output logic              cfg_ready,
  output logic [0:0]        enable,
  output logic [0:ADDR_W-1] address,
  output logic [0:0]        data_in,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Six bits covers the 36 writes of a default frame without wrapping.
  localparam int               CNT_W   = 6;
  localparam int               IDX_W   = ADDR_W - 1;
  localparam logic [CNT_W-1:0] LAST_K  = CNT_W'(NUM_MEM * BITS_PER_MEM - 1);
  localparam logic [CNT_W-1:0] BPM_CNT = CNT_W'(BITS_PER_MEM);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [0:ADDR_W-1] addr_q, addr_d;
  logic              data_q, data_d;
  logic              err_q, err_d;

  logic is_busy;
  logic start_new;
  logic transfer;
  logic write_ok;

  // Abort always wins over start; a transfer needs the loader to be in LOAD.
  assign is_busy   = (state_q == LOAD) || (state_q == WRITE);
  assign start_new = ((state_q == IDLE) || (state_q == DONE)) && start && !abort;
  assign transfer  = (state_q == LOAD) && cfg_valid && !abort;
  assign write_ok  = (state_q == WRITE) && !abort;

  // State register.
  always_ff @(posedge prog_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start && !abort) state_d = LOAD;
      LOAD: begin
        if (abort)          state_d = IDLE;
        else if (cfg_valid) state_d = WRITE;
      end
      WRITE: begin
        if (abort)                state_d = IDLE;
        else if (cnt_q == LAST_K) state_d = DONE;
        else                      state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; abort kills a write strobe in its own cycle.
  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    enable    = 1'b0;
    case (state_q)
      LOAD: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
      end
      WRITE: begin
        busy      = 1'b1;
        enable[0] = !abort;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: bit counter, write address/data, sticky error.
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    err_d  = err_q;
    if (start_new) begin
      cnt_d = '0;
      err_d = 1'b0;
    end
    if (is_busy && (abort || start)) err_d = 1'b1;
    // Address and data are captured at the transfer edge and held until the
    // next transfer, so they are stable for the whole enable cycle.
    if (transfer) begin
      data_d              = cfg_data;
      addr_d[0]           = 1'(cnt_q % BPM_CNT);
      addr_d[1:ADDR_W-1]  = IDX_W'(cnt_q / BPM_CNT);
    end
    // The counter stops at the last bit rather than rolling over.
    if (write_ok && (cnt_q != LAST_K)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Datapath registers.
  always_ff @(posedge prog_clk) begin
    if (reset) begin
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign address    = addr_q;
  assign data_in[0] = data_q;
  assign err        = err_q;

endmodule

// File: tb/tb_sb_config_loader.sv
// Self-checking bench for sb_config_loader: randomized frames plus directed
// stall, start-while-busy, abort, mid-load reset and start/abort cases.
module tb_sb_config_loader;

  localparam int NUM_MEM = 18;
  localparam int BPM     = 2;
  localparam int ADDR_W  = 6;
  localparam int TOTAL   = NUM_MEM * BPM;

  logic              prog_clk = 1'b0;
  logic              reset, start, abort, cfg_valid, cfg_data;
  logic              cfg_ready;
  logic [0:0]        enable;
  logic [0:ADDR_W-1] address;
  logic [0:0]        data_in;
  logic              busy, done, err;

  int checks = 0;
  int errors = 0;

  // One write as seen by the switch block: memory index, bit select, data.
  typedef struct packed {
    logic [4:0] idx;
    logic       sel;
    logic       d;
  } wr_t;

  wr_t exp_q[$];
  wr_t got_q[$];
  int  exp_k;

  logic xfer_prev = 1'b0;
  logic en_prev   = 1'b0;
  int   cyc       = 0;
  int   first_en  = -1;
  int   last_en   = -1;
  int   b2b       = 0;
  bit   mon_on    = 1'b0;
  wr_t  mon_w;

  always #5 prog_clk = ~prog_clk;

  sb_config_loader #(
    .NUM_MEM     (NUM_MEM),
    .BITS_PER_MEM(BPM),
    .ADDR_W      (ADDR_W)
  ) dut (
    .prog_clk (prog_clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .cfg_valid(cfg_valid),
    .cfg_data (cfg_data),
    .cfg_ready(cfg_ready),
    .enable   (enable),
    .address  (address),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: a write strobe must follow each accepted bit in the very next
  // cycle (unless aborted), and every strobe is logged for the scoreboard.
  always @(negedge prog_clk) begin
    cyc++;
    if (mon_on) begin
      check("enable_after_transfer", 32'(enable[0]), 32'(xfer_prev && !abort));
      if (enable[0]) begin
        check("ready_low_in_write", 32'(cfg_ready), 32'd0);
        check("busy_in_write", 32'(busy), 32'd1);
        mon_w.idx = address[1:ADDR_W-1];
        mon_w.sel = address[0];
        mon_w.d   = data_in[0];
        got_q.push_back(mon_w);
        if (en_prev) b2b++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end
      en_prev   = enable[0];
      xfer_prev = cfg_valid && cfg_ready && !reset && !abort;
    end
  end

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic clear_log();
    exp_q.delete();
    got_q.delete();
    first_en = -1;
    last_en  = -1;
    b2b      = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_k = 0;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!cfg_ready && guard < 20) begin
      step();
      guard++;
    end
    if (!cfg_ready) check("ready_wait", 32'(cfg_ready), 32'd1);
  endtask

  // Offer one bit after 'idle' invalid cycles; the expected write follows
  // directly from the bit's position k in the frame.
  task automatic send_bit(input logic b, input int idle, input logic with_start);
    wr_t w;
    repeat (idle) begin
      cfg_valid = 1'b0;
      step();
    end
    cfg_valid = 1'b1;
    cfg_data  = b;
    wait_ready();
    if (cfg_ready) begin
      start = with_start;
      step();
      start = 1'b0;
      w.idx = 5'(exp_k / BPM);
      w.sel = 1'(exp_k % BPM);
      w.d   = b;
      exp_q.push_back(w);
      exp_k++;
    end
  endtask

  task automatic send_random(input int from_k, input int to_k, input int max_idle);
    for (int k = from_k; k < to_k; k++)
      send_bit(1'($urandom), int'($urandom_range(0, max_idle)), 1'b0);
  endtask

  task automatic finish_frame();
    cfg_valid = 1'b0;
    step();
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(tag, {25'b0, got_q[i]}, {25'b0, exp_q[i]});
    clear_log();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_enable"},    32'(enable[0]), 32'd0);
    check({tag, "_address"},   32'(address),   32'd0);
    check({tag, "_data_in"},   32'(data_in[0]), 32'd0);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_err"},       32'(err),       32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset wins over start, abort and cfg_valid held high.
    reset = 1'b1; start = 1'b1; abort = 1'b1; cfg_valid = 1'b1; cfg_data = 1'b1;
    repeat (3) step();
    check_idle_outputs("reset");
    reset = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = 1'b0;
    step();
    mon_on = 1'b1;

    // cfg_valid in IDLE is ignored without error.
    cfg_valid = 1'b1;
    repeat (4) step();
    check("idle_valid_err", 32'(err), 32'd0);
    check("idle_valid_busy", 32'(busy), 32'd0);
    check("idle_valid_writes", 32'(got_q.size()), 32'd0);
    cfg_valid = 1'b0;

    // Simultaneous start and abort from IDLE: abort wins, nothing happens.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_ready", 32'(cfg_ready), 32'd0);
    step();
    check("start_abort_busy2", 32'(busy), 32'd0);
    check("start_abort_err", 32'(err), 32'd0);

    // Full frame: alternating 1,0 with cfg_valid held high.
    clear_log();
    pulse_start();
    check("load_ready", 32'(cfg_ready), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    for (int k = 0; k < TOTAL; k++) send_bit(k % 2 == 0, 0, 1'b0);
    finish_frame();
    check("full_done", 32'(done), 32'd1);
    check("full_err", 32'(err), 32'd0);
    check("full_busy", 32'(busy), 32'd0);
    check("full_span", 32'(last_en - first_en), 32'(2 * (TOTAL - 1)));
    check("full_back_to_back", 32'(b2b), 32'd0);
    compare_writes("full_write");

    // cfg_valid in DONE is ignored; done holds.
    cfg_valid = 1'b1;
    repeat (3) step();
    check("done_valid_done", 32'(done), 32'd1);
    check("done_valid_err", 32'(err), 32'd0);
    check("done_valid_writes", 32'(got_q.size()), 32'd0);
    cfg_valid = 1'b0;

    // Backpressure: 5-cycle gap after bit 10 stalls the loader.
    pulse_start();
    check("restart_done_cleared", 32'(done), 32'd0);
    send_random(0, 11, 0);
    cfg_valid = 1'b0;
    step();
    repeat (5) step();
    check("stall_writes", 32'(got_q.size()), 32'(exp_q.size()));
    check("stall_ready", 32'(cfg_ready), 32'd1);
    check("stall_busy", 32'(busy), 32'd1);
    send_random(11, TOTAL, 2);
    finish_frame();
    if (got_q.size() > 11) begin
      check("stall_next_idx", 32'(got_q[11].idx), 32'd5);
      check("stall_next_sel", 32'(got_q[11].sel), 32'd1);
    end
    check("stall_done", 32'(done), 32'd1);
    check("stall_b2b", 32'(b2b), 32'd0);
    compare_writes("stall_write");

    // Start while busy at bit 7: ignored, err sticks, frame still completes.
    pulse_start();
    send_random(0, 7, 0);
    send_bit(1'($urandom), 0, 1'b1);
    check("busy_start_err", 32'(err), 32'd1);
    check("busy_start_busy", 32'(busy), 32'd1);
    send_random(8, TOTAL, 1);
    finish_frame();
    check("busy_start_done", 32'(done), 32'd1);
    check("busy_start_err_sticky", 32'(err), 32'd1);
    compare_writes("busy_start_write");

    // Abort in the enable cycle of bit 20.
    pulse_start();
    check("abort_err_cleared", 32'(err), 32'd0);
    send_random(0, 20, 0);
    cfg_valid = 1'b1;
    cfg_data  = 1'($urandom);
    wait_ready();
    step();
    abort     = 1'b1;
    cfg_valid = 1'b0;
    #1;
    check("abort_enable_low", 32'(enable[0]), 32'd0);
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err), 32'd1);
    check("abort_ready", 32'(cfg_ready), 32'd0);
    compare_writes("abort_write");
    pulse_start();
    send_random(0, TOTAL, 2);
    finish_frame();
    if (got_q.size() > 0) begin
      check("abort_restart_idx", 32'(got_q[0].idx), 32'd0);
      check("abort_restart_sel", 32'(got_q[0].sel), 32'd0);
    end
    check("abort_restart_done", 32'(done), 32'd1);
    check("abort_restart_err", 32'(err), 32'd0);
    compare_writes("abort_restart_write");

    // Mid-load reset at bit 12: frame discarded, no further writes.
    pulse_start();
    send_random(0, 12, 0);
    cfg_data = 1'($urandom);
    step();
    reset = 1'b1;
    step();
    check_idle_outputs("midreset");
    reset = 1'b0;
    repeat (4) step();
    check("midreset_writes", 32'(got_q.size()), 32'(exp_q.size()));
    check("midreset_busy", 32'(busy), 32'd0);
    cfg_valid = 1'b0;
    compare_writes("midreset_write");
    pulse_start();
    send_random(0, TOTAL, 1);
    finish_frame();
    check("midreset_reload_done", 32'(done), 32'd1);
    compare_writes("midreset_reload_write");

    // Randomized frames with random valid gaps.
    for (int f = 0; f < 3; f++) begin
      pulse_start();
      send_random(0, TOTAL, 3);
      finish_frame();
      check("rand_done", 32'(done), 32'd1);
      check("rand_err", 32'(err), 32'd0);
      check("rand_b2b", 32'(b2b), 32'd0);
      compare_writes("rand_write");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
